// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline stage for the RV32 core.
// Two-entry skid-buffered register slice with valid/ready handshakes, flush
// with bubble insertion, and saturating stall/flush performance counters.
// in_ready depends on registered state only, so EX back-pressure never
// forms a combinational path back into decode.

module id_ex_pipe #(
    parameter int                 XLEN     = 32,
    parameter int                 INST_W   = 32,
    parameter int                 RADDR_W  = 5,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h0000_0013,
    parameter int                 CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,

    // Decode side
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INST_W-1:0]  inst_i,
    input  logic [XLEN-1:0]    inst_addr_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic               rd_w_en_i,

    input  logic               flush,

    // Execute side
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INST_W-1:0]  inst_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [XLEN-1:0]    rs1_data_o,
    output logic [XLEN-1:0]    rs2_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               rd_w_en_o,

    // Performance debug
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   flush_cnt_o
);

    typedef struct packed {
        logic [INST_W-1:0]  inst;
        logic [XLEN-1:0]    addr;
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic [RADDR_W-1:0] rd;
        logic               wen;
    } payload_t;

    localparam payload_t BUBBLE = '{
        inst: NOP_INST,
        addr: '0,
        rs1:  '0,
        rs2:  '0,
        rd:   '0,
        wen:  1'b0
    };

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    payload_t         main_q, main_d;
    payload_t         skid_q, skid_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    payload_t         in_beat;
    logic             accept;
    logic             main_free;

    assign in_beat = '{
        inst: inst_i,
        addr: inst_addr_i,
        rs1:  rs1_data_i,
        rs2:  rs2_data_i,
        rd:   rd_addr_i,
        wen:  rd_w_en_i
    };

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & in_ready;
    // Main can take a new beat when it is empty or its beat is leaving.
    assign main_free = ~main_valid_q | out_ready;

    // Next-state selection for the main and skid entries.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        if (flush) begin
            // A pop this cycle has already been seen by EX; everything else dies.
            main_d       = BUBBLE;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_beat;
                end
            end else begin
                main_d       = accept ? in_beat : BUBBLE;
                main_valid_d = accept;
            end
        end else if (accept) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (main_valid_q && !out_ready && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // Control state, main payload and counters with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= BUBBLE;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Skid payload register.
    always_ff @(posedge clk) begin
        // NOTE: skid payload is data-only storage guarded by skid_valid_q and
        // never reaches the outputs while invalid, so it carries no reset.
        skid_q <= skid_d;
    end

    // Main entry drives EX; an invalid main always holds the bubble payload.
    assign out_valid   = main_valid_q;
    assign inst_o      = main_q.inst;
    assign inst_addr_o = main_q.addr;
    assign rs1_data_o  = main_q.rs1;
    assign rs2_data_o  = main_q.rs2;
    assign rd_addr_o   = main_q.rd;
    assign rd_w_en_o   = main_q.wen;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed, table-driven bench for id_ex_pipe.
// A default-width instance and a CNT_W=2 instance share all inputs.

module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] inst_i, inst_addr_i, rs1_data_i, rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_w_en_i;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, rd_w_en_o;
    logic [31:0] inst_o, inst_addr_o, rs1_data_o, rs2_data_o;
    logic [4:0]  rd_addr_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic        s_in_ready, s_out_valid, s_rd_w_en_o;
    logic [31:0] s_inst_o, s_inst_addr_o, s_rs1_data_o, s_rs2_data_o;
    logic [4:0]  s_rd_addr_o;
    logic [1:0]  s_stall_cnt_o, s_flush_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_pipe u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_addr_i(rd_addr_i), .rd_w_en_i(rd_w_en_i),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
        .rd_addr_o(rd_addr_o), .rd_w_en_o(rd_w_en_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    id_ex_pipe #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .rd_addr_i(rd_addr_i), .rd_w_en_i(rd_w_en_i),
        .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .inst_o(s_inst_o), .inst_addr_o(s_inst_addr_o),
        .rs1_data_o(s_rs1_data_o), .rs2_data_o(s_rs2_data_o),
        .rd_addr_o(s_rd_addr_o), .rd_w_en_o(s_rd_w_en_o),
        .stall_cnt_o(s_stall_cnt_o), .flush_cnt_o(s_flush_cnt_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        wen;
    } beat_t;

    // One cycle of stimulus and the state expected right after the edge.
    typedef struct {
        bit iv;
        int id;
        bit fl;
        bit ordy;
        bit e_ir;
        bit e_ov;
        int e_id;     // -1 = bubble payload
        int e_stall;
        int e_flush;
    } vec_t;

    vec_t vecs[$];

    // Beat k payload; beat 0 is the addi x1,x0,10 at PC 0x100.
    function automatic beat_t beat(int k);
        beat_t b;
        if (k < 0) begin
            b = '{inst: 32'h0000_0013, pc: 32'h0, rs1: 32'h0, rs2: 32'h0, rd: 5'd0, wen: 1'b0};
        end else if (k == 0) begin
            b = '{inst: 32'h00A0_0093, pc: 32'h100, rs1: 32'h0, rs2: 32'h0, rd: 5'd1, wen: 1'b1};
        end else begin
            b.inst = 32'hA500_0000 + 32'(k);
            b.pc   = 32'h100 + 32'(4 * k);
            b.rs1  = 32'h1111_0000 + 32'(k);
            b.rs2  = 32'hFFFF_0000 - 32'(k);
            b.rd   = 5'(k);
            b.wen  = k[0];
        end
        return b;
    endfunction

    function automatic vec_t mk(bit iv, int id, bit fl, bit ordy, bit e_ir, bit e_ov,
                                int e_id, int e_stall, int e_flush);
        vec_t v;
        v.iv = iv; v.id = id; v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_id = e_id;
        v.e_stall = e_stall; v.e_flush = e_flush;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(string tag, logic ir, logic ov, logic [31:0] inst,
                              logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
                              logic [4:0] rd, logic wen, bit e_ir, bit e_ov, int e_id);
        beat_t e;
        e = beat(e_id);
        check({tag, ".in_ready"},  64'(ir),   64'(e_ir));
        check({tag, ".out_valid"}, 64'(ov),   64'(e_ov));
        check({tag, ".inst"},      64'(inst), 64'(e.inst));
        check({tag, ".pc"},        64'(pc),   64'(e.pc));
        check({tag, ".rs1"},       64'(rs1),  64'(e.rs1));
        check({tag, ".rs2"},       64'(rs2),  64'(e.rs2));
        check({tag, ".rd"},        64'(rd),   64'(e.rd));
        check({tag, ".wen"},       64'(wen),  64'(e.wen));
    endtask

    task automatic drive(bit iv, int id, bit fl, bit ordy);
        beat_t b;
        b = beat(id < 0 ? 0 : id);
        in_valid    = iv;
        inst_i      = b.inst;
        inst_addr_i = b.pc;
        rs1_data_i  = b.rs1;
        rs2_data_i  = b.rs2;
        rd_addr_i   = b.rd;
        rd_w_en_i   = b.wen;
        flush       = fl;
        out_ready   = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Single beat, then idle.
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, -1, 0, 0));
        // Streaming 8 beats with 1-cycle latency.
        for (int k = 1; k <= 8; k++) vecs.push_back(mk(1, k, 0, 1, 1, 1, k, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, -1, 0, 0));
        // Back-pressure: A=9 held, B=10 in skid, 11 refused.
        vecs.push_back(mk(1, 9, 0, 0, 1, 1, 9, 0, 0));
        vecs.push_back(mk(1, 10, 0, 0, 0, 1, 9, 1, 0));
        vecs.push_back(mk(1, 11, 0, 0, 0, 1, 9, 2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 10, 2, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, -1, 2, 0));
        // Flush with both entries full and C=14 offered.
        vecs.push_back(mk(1, 12, 0, 0, 1, 1, 12, 2, 0));
        vecs.push_back(mk(1, 13, 0, 0, 0, 1, 12, 3, 0));
        vecs.push_back(mk(1, 14, 1, 0, 1, 0, -1, 4, 1));
        // Flush discards a beat accepted in the same cycle.
        vecs.push_back(mk(1, 15, 1, 1, 1, 0, -1, 4, 2));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, -1, 4, 2));
        // Flush coinciding with pop of A=16, B=17 in skid dropped.
        vecs.push_back(mk(1, 16, 0, 0, 1, 1, 16, 4, 2));
        vecs.push_back(mk(1, 17, 0, 0, 0, 1, 16, 5, 2));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, -1, 5, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, -1, 5, 3));
        // Skid drains while a beat is refused, then a fresh beat streams.
        vecs.push_back(mk(1, 18, 0, 0, 1, 1, 18, 5, 3));
        vecs.push_back(mk(1, 19, 0, 0, 0, 1, 18, 6, 3));
        vecs.push_back(mk(1, 20, 0, 1, 1, 1, 19, 6, 3));
        vecs.push_back(mk(1, 21, 0, 1, 1, 1, 21, 6, 3));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, -1, 6, 3));

        rst = 1'b1;
        drive(0, 0, 0, 0);
        step();
        step();
        check_outs("reset", in_ready, out_valid, inst_o, inst_addr_o, rs1_data_o,
                   rs2_data_o, rd_addr_o, rd_w_en_o, 1, 0, -1);
        check("reset.stall", 64'(stall_cnt_o), 64'd0);
        check("reset.flush", 64'(flush_cnt_o), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].fl, vecs[i].ordy);
            step();
            check_outs($sformatf("v%0d", i), in_ready, out_valid, inst_o, inst_addr_o,
                       rs1_data_o, rs2_data_o, rd_addr_o, rd_w_en_o,
                       vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_id);
            check($sformatf("v%0d.stall", i), 64'(stall_cnt_o), 64'(vecs[i].e_stall));
            check($sformatf("v%0d.flush", i), 64'(flush_cnt_o), 64'(vecs[i].e_flush));
        end

        // Stall saturation on the CNT_W=2 instance, starting from reset.
        rst = 1'b1;
        drive(0, 0, 0, 0);
        step();
        check("sat.reset.stall", 64'(s_stall_cnt_o), 64'd0);
        check("sat.reset.flush", 64'(s_flush_cnt_o), 64'd0);
        check("sat.reset.valid", 64'(s_out_valid), 64'd0);
        rst = 1'b0;
        drive(1, 5, 0, 0);
        step();
        check_outs("sat.load", s_in_ready, s_out_valid, s_inst_o, s_inst_addr_o,
                   s_rs1_data_o, s_rs2_data_o, s_rd_addr_o, s_rd_w_en_o, 1, 1, 5);
        check("sat.load.stall", 64'(s_stall_cnt_o), 64'd0);
        drive(0, 0, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            step();
            check($sformatf("sat.stall%0d", n), 64'(s_stall_cnt_o), 64'(n > 3 ? 3 : n));
            check($sformatf("wide.stall%0d", n), 64'(stall_cnt_o), 64'(n));
        end
        // Reset mid-stall clears everything.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.sat.stall", 64'(s_stall_cnt_o), 64'd0);
        check("midrst.stall", 64'(stall_cnt_o), 64'd0);
        check("midrst.flush", 64'(flush_cnt_o), 64'd0);
        check("midrst.valid", 64'(out_valid), 64'd0);
        check("midrst.ready", 64'(in_ready), 64'd1);
        // Flush counter saturation.
        drive(0, 0, 1, 1);
        for (int n = 1; n <= 4; n++) begin
            step();
            check($sformatf("sat.flush%0d", n), 64'(s_flush_cnt_o), 64'(n > 3 ? 3 : n));
        end
        drive(0, 0, 0, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
